// File: rtl/mmio_gpio.sv
// mmio_gpio: memory-mapped GPIO peripheral occupying an 8-word window at BASE_ADDR.
// Provides an output register with set/clear aliases, synchronised inputs,
// per-bit edge detection (selectable polarity, sticky W1C status, mask) and a
// registered level interrupt.
// Optional input debounce stage: define GPIO_DEBOUNCE_EN.
module mmio_gpio #(
    parameter logic [15:0] BASE_ADDR       = 16'hC000,
    parameter int          OUT_W           = 10,
    parameter int          IN_W            = 10,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      addr,
    input  logic             we,
    input  logic             re,
    input  logic [15:0]      wdata,
    output logic [15:0]      rdata,
    output logic             hit,
    input  logic [IN_W-1:0]  gpio_in,
    output logic [OUT_W-1:0] gpio_out,
    output logic             irq
);

    localparam logic [2:0] OFF_OUT_DATA    = 3'd0;
    localparam logic [2:0] OFF_IN_DATA     = 3'd1;
    localparam logic [2:0] OFF_EDGE_STATUS = 3'd2;
    localparam logic [2:0] OFF_EDGE_MASK   = 3'd3;
    localparam logic [2:0] OFF_EDGE_POL    = 3'd4;
    localparam logic [2:0] OFF_OUT_SET     = 3'd5;
    localparam logic [2:0] OFF_OUT_CLR     = 3'd6;

    logic             wr_s;
    logic             rd_s;
    logic [2:0]       off_s;
    logic [OUT_W-1:0] wd_out_s;
    logic [IN_W-1:0]  wd_in_s;

    logic [OUT_W-1:0] out_r;
    logic [OUT_W-1:0] out_nxt_s;
    logic [IN_W-1:0]  status_r;
    logic [IN_W-1:0]  status_nxt_s;
    logic [IN_W-1:0]  mask_r;
    logic [IN_W-1:0]  mask_nxt_s;
    logic [IN_W-1:0]  pol_r;
    logic [IN_W-1:0]  pol_nxt_s;
    logic [IN_W-1:0]  w1c_s;
    logic [15:0]      rdata_r;
    logic [15:0]      rdata_nxt_s;
    logic [15:0]      rd_val_s;
    logic             irq_r;

    logic [IN_W-1:0]  sync1_r;
    logic [IN_W-1:0]  sync2_r;
    logic [IN_W-1:0]  cond_s;
    logic [IN_W-1:0]  cond_q_r;
    logic [IN_W-1:0]  edge_s;

    // Upper write-data bits beyond the register widths are deliberately dropped.
    logic unused_s;
    assign unused_s = ^{wdata, DEBOUNCE_CYCLES[0]};

    assign hit      = (addr[15:3] == BASE_ADDR[15:3]);
    assign wr_s     = we & hit;
    assign rd_s     = re & hit;
    assign off_s    = addr[2:0];
    assign wd_out_s = wdata[OUT_W-1:0];
    assign wd_in_s  = wdata[IN_W-1:0];

    assign gpio_out = out_r;
    assign rdata    = rdata_r;
    assign irq      = irq_r;

    // Two-flop synchroniser and previous-value register for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r  <= {IN_W{1'b0}};
            sync2_r  <= {IN_W{1'b0}};
            cond_q_r <= {IN_W{1'b0}};
        end else begin
            sync1_r  <= gpio_in;
            sync2_r  <= sync1_r;
            cond_q_r <= cond_s;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r [IN_W];
    logic [IN_W-1:0]  cond_r;

    // Per-bit debounce: cond follows the synchronised value only after it has differed long enough
    always_ff @(posedge clk) begin
        if (rst) begin
            cond_r <= {IN_W{1'b0}};
            for (int i = 0; i < IN_W; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < IN_W; i++) begin
                if (sync2_r[i] == cond_r[i]) begin
                    cnt_r[i] <= {CNT_W{1'b0}};
                end else if (cnt_r[i] == CNT_LAST) begin
                    cond_r[i] <= sync2_r[i];
                    cnt_r[i]  <= {CNT_W{1'b0}};
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    assign cond_s = cond_r;
`else
    assign cond_s = sync2_r;
`endif

    // Edge detect: rising where polarity bit is 0, falling where it is 1
    always_comb begin
        edge_s = (cond_s & ~cond_q_r & ~pol_r) | (~cond_s & cond_q_r & pol_r);
    end

    // Next value of the output register from direct, set and clear writes
    always_comb begin
        out_nxt_s = out_r;
        if (wr_s) begin
            case (off_s)
                OFF_OUT_DATA: out_nxt_s = wd_out_s;
                OFF_OUT_SET:  out_nxt_s = out_r | wd_out_s;
                OFF_OUT_CLR:  out_nxt_s = out_r & ~wd_out_s;
                default:      out_nxt_s = out_r;
            endcase
        end else begin
            out_nxt_s = out_r;
        end
    end

    // Next values of mask, polarity and sticky status; a detected edge beats a W1C
    always_comb begin
        mask_nxt_s = mask_r;
        pol_nxt_s  = pol_r;
        w1c_s      = {IN_W{1'b0}};
        if (wr_s) begin
            case (off_s)
                OFF_EDGE_STATUS: w1c_s      = wd_in_s;
                OFF_EDGE_MASK:   mask_nxt_s = wd_in_s;
                OFF_EDGE_POL:    pol_nxt_s  = wd_in_s;
                default:         w1c_s      = {IN_W{1'b0}};
            endcase
        end else begin
            w1c_s = {IN_W{1'b0}};
        end
        status_nxt_s = (status_r & ~w1c_s) | edge_s;
    end

    // Read mux, zero-extended; write-only and reserved offsets read as zero
    always_comb begin
        rd_val_s = 16'h0000;
        case (off_s)
            OFF_OUT_DATA:    rd_val_s[OUT_W-1:0] = out_r;
            OFF_IN_DATA:     rd_val_s[IN_W-1:0]  = cond_s;
            OFF_EDGE_STATUS: rd_val_s[IN_W-1:0]  = status_r;
            OFF_EDGE_MASK:   rd_val_s[IN_W-1:0]  = mask_r;
            OFF_EDGE_POL:    rd_val_s[IN_W-1:0]  = pol_r;
            default:         rd_val_s            = 16'h0000;
        endcase
    end

    // Read data holds between reads; a strobe outside the window returns zero
    always_comb begin
        rdata_nxt_s = rdata_r;
        if (rd_s) begin
            rdata_nxt_s = rd_val_s;
        end else if (re) begin
            rdata_nxt_s = 16'h0000;
        end else begin
            rdata_nxt_s = rdata_r;
        end
    end

    // Architectural registers, read data and interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r    <= {OUT_W{1'b0}};
            status_r <= {IN_W{1'b0}};
            mask_r   <= {IN_W{1'b0}};
            pol_r    <= {IN_W{1'b0}};
            rdata_r  <= 16'h0000;
            irq_r    <= 1'b0;
        end else begin
            out_r    <= out_nxt_s;
            status_r <= status_nxt_s;
            mask_r   <= mask_nxt_s;
            pol_r    <= pol_nxt_s;
            rdata_r  <= rdata_nxt_s;
            irq_r    <= |(status_r & mask_r);
        end
    end

endmodule

// File: tb/tb_mmio_gpio.sv
// tb_mmio_gpio: self-checking bench for mmio_gpio. Expected read data is
// queued when a read is issued and popped when rdata is sampled.
module tb_mmio_gpio;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [15:0] wdata = 16'h0000;
    logic [15:0] rdata;
    logic        hit;
    logic [9:0]  gpio_in = 10'h000;
    logic [9:0]  gpio_out;
    logic        irq;

`ifdef GPIO_DEBOUNCE_EN
    localparam int IN_LAT = 6;
`else
    localparam int IN_LAT = 2;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_q[$];

    mmio_gpio #(
        .BASE_ADDR(16'hC000), .OUT_W(10), .IN_W(10), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .we(we), .re(re), .wdata(wdata),
        .rdata(rdata), .hit(hit), .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        addr = a; wdata = d; we = 1'b1;
        cyc();
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] got);
        addr = a; re = 1'b1;
        cyc();
        re = 1'b0;
        got = rdata;
    endtask

    task automatic test_reset();
        logic [15:0] got, want;
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        vectors++;
        if (gpio_out !== 10'h000) begin miscompares++; $display("FAIL reset_gpio_out: got %h want 000", gpio_out); end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b want 0", irq); end
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(16'h0000);
            bus_read(16'hC000 + 16'(i), got);
            want = exp_q.pop_front(); vectors++;
            if (got !== want) begin miscompares++; $display("FAIL reset_read_off%0d: got %h want %h", i, got, want); end
        end
    endtask

    task automatic test_debounce();
        logic [15:0] got, want;
        gpio_in = 10'h004;
        repeat (3) cyc();
        gpio_in = 10'h000;
        repeat (8) cyc();
        exp_q.push_back(16'h0000); bus_read(16'hC001, got);
        want = exp_q.pop_front(); vectors++;
        if (got !== want) begin miscompares++; $display("FAIL debounce_glitch_in: got %h want %h", got, want); end
        exp_q.push_back(16'h0000); bus_read(16'hC002, got);
        want = exp_q.pop_front(); vectors++;
        if (got !== want) begin miscompares++; $display("FAIL debounce_glitch_status: got %h want %h", got, want); end
        gpio_in = 10'h004;
        repeat (5) cyc();
        exp_q.push_back(16'h0000); bus_read(16'hC001, got);
        want = exp_q.pop_front(); vectors++;
        if (got !== want) begin miscompares++; $display("FAIL debounce_early: got %h want %h", got, want); end
        gpio_in = 10'h000;
        exp_q.push_back(16'h0004); bus_read(16'hC001, got);
        want = exp_q.pop_front(); vectors++;
        if (got !== want) begin miscompares++; $display("FAIL debounce_settled: got %h want %h", got, want); end
        repeat (12) cyc();
        bus_write(16'hC002, 16'hFFFF);
    endtask

    task automatic test_out_writes();
        logic [15:0] got, want;
        bus_write(16'hC000, 16'hFFFF);
        vectors++;
        if (gpio_out !== 10'h3FF) begin miscompares++; $display("FAIL out_truncate: got %h want 3FF", gpio_out); end
        exp_q.push_back(16'h03FF); bus_read(16'hC000, got);
        want = exp_q.pop_front(); vectors++;
        if (got !== want) begin miscompares++; $display("FAIL out_zero_ext: got %h want %h", got, want); end
        bus_write(16'hC007, 16'hFFFF);
        exp_q.push_back(16'h0000); bus_read(16'hC007, got);
        want = exp_q.pop_front(); vectors++;
        if (got !== want) begin miscompares++; $display("FAIL reserved_read: got %h want %h", got, want); end
        bus_write(16'hC000, 16'h03FF);
        bus_write(16'hC006, 16'h000F);
        vectors++;
        if (gpio_out !== 10'h3F0) begin miscompares++; $display("FAIL out_clr: got %h want 3F0", gpio_out); end
        bus_write(16'hC005, 16'h0100);
        vectors++;
        if (gpio_out !== 10'h3F0) begin miscompares++; $display("FAIL out_set: got %h want 3F0", gpio_out); end
        exp_q.push_back(16'h03F0); bus_read(16'hC000, got);
        want = exp_q.pop_front(); vectors++;
        if (got !== want) begin miscompares++; $display("FAIL out_read: got %h want %h", got, want); end
        for (int i = 5; i < 7; i++) begin
            exp_q.push_back(16'h0000); bus_read(16'hC000 + 16'(i), got);
            want = exp_q.pop_front(); vectors++;
            if (got !== want) begin miscompares++; $display("FAIL alias_read_off%0d: got %h want %h", i, got, want); end
        end
    endtask

    task automatic test_decode();
        logic [15:0] got, want;
        logic [15:0] bad_addr [2];
        bad_addr[0] = 16'hC008;
        bad_addr[1] = 16'h1000;
        addr = 16'hC007; #1;
        vectors++;
        if (hit !== 1'b1) begin miscompares++; $display("FAIL hit_top_of_window: got %b want 1", hit); end
        for (int i = 0; i < 2; i++) begin
            addr = bad_addr[i]; wdata = 16'hFFFF; we = 1'b1; #1;
            vectors++;
            if (hit !== 1'b0) begin miscompares++; $display("FAIL hit_outside_%h: got %b want 0", bad_addr[i], hit); end
            cyc();
            we = 1'b0;
            vectors++;
            if (gpio_out !== 10'h3F0) begin miscompares++; $display("FAIL write_outside_%h: got %h want 3F0", bad_addr[i], gpio_out); end
        end
        exp_q.push_back(16'h03F0); bus_read(16'hC000, got);
        want = exp_q.pop_front(); vectors++;
        if (got !== want) begin miscompares++; $display("FAIL decode_read_out: got %h want %h", got, want); end
        exp_q.push_back(16'h0000); bus_read(16'h1000, got);
        want = exp_q.pop_front(); vectors++;
        if (got !== want) begin miscompares++; $display("FAIL miss_read_zero: got %h want %h", got, want); end
        gpio_in = 10'h2A5;
        repeat (IN_LAT) cyc();
        exp_q.push_back(16'h02A5); bus_read(16'hC001, got);
        want = exp_q.pop_front(); vectors++;
        if (got !== want) begin miscompares++; $display("FAIL in_data: got %h want %h", got, want); end
        exp_q.push_back(16'h02A5); bus_read(16'hC002, got);
        want = exp_q.pop_front(); vectors++;
        if (got !== want) begin miscompares++; $display("FAIL rising_status: got %h want %h", got, want); end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL masked_irq: got %b want 0", irq); end
        bus_write(16'hC002, 16'hFFFF);
        exp_q.push_back(16'h0000); bus_read(16'hC002, got);
        want = exp_q.pop_front(); vectors++;
        if (got !== want) begin miscompares++; $display("FAIL w1c_all: got %h want %h", got, want); end
    endtask

    task automatic test_edge_irq();
        logic [15:0] got, want;
        bus_write(16'hC003, 16'h0001);
        bus_write(16'hC004, 16'h0000);
        gpio_in = 10'h2A4;
        repeat (IN_LAT + 2) cyc();
        bus_write(16'hC002, 16'hFFFF);
        cyc();
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_idle: got %b want 0", irq); end
        gpio_in = 10'h2A5;
        repeat (IN_LAT + 1) cyc();
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_lag: got %b want 0", irq); end
        exp_q.push_back(16'h0001); bus_read(16'hC002, got);
        want = exp_q.pop_front(); vectors++;
        if (got !== want) begin miscompares++; $display("FAIL edge_status: got %h want %h", got, want); end
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_set: got %b want 1", irq); end
        bus_write(16'hC002, 16'h0001);
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_hold_after_w1c: got %b want 1", irq); end
        exp_q.push_back(16'h0000); bus_read(16'hC002, got);
        want = exp_q.pop_front(); vectors++;
        if (got !== want) begin miscompares++; $display("FAIL edge_w1c: got %h want %h", got, want); end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear: got %b want 0", irq); end
    endtask

    task automatic test_set_beats_clear();
        logic [15:0] got, want;
        bus_write(16'hC004, 16'h0002);
        gpio_in = 10'h2A7;
        repeat (IN_LAT + 2) cyc();
        exp_q.push_back(16'h0000); bus_read(16'hC002, got);
        want = exp_q.pop_front(); vectors++;
        if (got !== want) begin miscompares++; $display("FAIL falling_pol_ignores_rise: got %h want %h", got, want); end
        gpio_in = 10'h2A5;
        repeat (IN_LAT) cyc();
        bus_write(16'hC002, 16'h0002);
        exp_q.push_back(16'h0002); bus_read(16'hC002, got);
        want = exp_q.pop_front(); vectors++;
        if (got !== want) begin miscompares++; $display("FAIL set_beats_clear: got %h want %h", got, want); end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL unmasked_bit_irq: got %b want 0", irq); end
    endtask

    task automatic test_pol_change();
        logic [15:0] got, want;
        bus_write(16'hC002, 16'hFFFF);
        bus_write(16'hC004, 16'h0001);
        repeat (3) cyc();
        exp_q.push_back(16'h0000); bus_read(16'hC002, got);
        want = exp_q.pop_front(); vectors++;
        if (got !== want) begin miscompares++; $display("FAIL pol_change_no_edge: got %h want %h", got, want); end
        exp_q.push_back(16'h0001); bus_read(16'hC004, got);
        want = exp_q.pop_front(); vectors++;
        if (got !== want) begin miscompares++; $display("FAIL pol_readback: got %h want %h", got, want); end
        bus_write(16'hC004, 16'h0000);
    endtask

    task automatic test_back_to_back();
        logic [15:0] got, want;
        exp_q.push_back(16'h03F0);
        addr = 16'hC000; wdata = 16'h0155; we = 1'b1; re = 1'b1;
        cyc();
        we = 1'b0; re = 1'b0; got = rdata;
        want = exp_q.pop_front(); vectors++;
        if (got !== want) begin miscompares++; $display("FAIL read_before_write: got %h want %h", got, want); end
        vectors++;
        if (gpio_out !== 10'h155) begin miscompares++; $display("FAIL same_cycle_write: got %h want 155", gpio_out); end
        bus_write(16'hC005, 16'h0200);
        vectors++;
        if (gpio_out !== 10'h355) begin miscompares++; $display("FAIL b2b_set: got %h want 355", gpio_out); end
        bus_write(16'hC006, 16'h0001);
        vectors++;
        if (gpio_out !== 10'h354) begin miscompares++; $display("FAIL b2b_clr: got %h want 354", gpio_out); end
        exp_q.push_back(16'h0354); bus_read(16'hC000, got);
        want = exp_q.pop_front(); vectors++;
        if (got !== want) begin miscompares++; $display("FAIL b2b_read: got %h want %h", got, want); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] got, want;
        bus_write(16'hC003, 16'h03FF);
        bus_write(16'hC004, 16'h0010);
        rst = 1'b1; addr = 16'hC000; wdata = 16'hFFFF; we = 1'b1;
        cyc();
        rst = 1'b0; we = 1'b0;
        vectors++;
        if (gpio_out !== 10'h000) begin miscompares++; $display("FAIL midreset_gpio_out: got %h want 000", gpio_out); end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL midreset_irq: got %b want 0", irq); end
        exp_q.push_back(16'h0000); bus_read(16'hC003, got);
        want = exp_q.pop_front(); vectors++;
        if (got !== want) begin miscompares++; $display("FAIL midreset_mask: got %h want %h", got, want); end
        exp_q.push_back(16'h0000); bus_read(16'hC004, got);
        want = exp_q.pop_front(); vectors++;
        if (got !== want) begin miscompares++; $display("FAIL midreset_pol: got %h want %h", got, want); end
        repeat (IN_LAT - 1) cyc();
        exp_q.push_back(16'h02A5); bus_read(16'hC002, got);
        want = exp_q.pop_front(); vectors++;
        if (got !== want) begin miscompares++; $display("FAIL post_reset_rise: got %h want %h", got, want); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
`ifdef GPIO_DEBOUNCE_EN
        test_debounce();
`endif
        test_out_writes();
        test_decode();
        test_edge_irq();
        test_set_beats_clear();
        test_pol_change();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
